// File: rtl/df_pkg.sv
// Shared state encoding and default widths for the dense-layer MAC sequencer.
package df_pkg;
    localparam int DF_DATA_W        = 16;
    localparam int DF_ACC_W         = 40;
    localparam int DF_FRAC_BITS     = 8;
    localparam int DF_DRAIN_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } df_state_e;
endpackage

// File: rtl/df_result_scaler.sv
// Combinational output stage: drop fractional bits, add bias, optional ReLU,
// saturate to the signed DATA_W range.
module df_result_scaler
    import df_pkg::*;
#(
    parameter int                       DATA_W    = DF_DATA_W,
    parameter int                       ACC_W     = DF_ACC_W,
    parameter int                       FRAC_BITS = DF_FRAC_BITS,
    parameter logic signed [DATA_W-1:0] BIAS      = {DATA_W{1'b0}},
    parameter bit                       RELU_EN   = 1'b1
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result
);
    // One guard bit above the accumulator so the bias add cannot overflow.
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted_s;
    logic signed [ACC_W:0]   biased_s;
    logic signed [ACC_W:0]   relu_s;

    // Scale, bias, rectify and clamp.
    always_comb begin
        shifted_s = acc >>> FRAC_BITS;
        biased_s  = {shifted_s[ACC_W-1], shifted_s}
                  + {{(ACC_W-DATA_W+1){BIAS[DATA_W-1]}}, BIAS};
        if (RELU_EN && biased_s[ACC_W]) begin
            relu_s = {(ACC_W+1){1'b0}};
        end else begin
            relu_s = biased_s;
        end
        if (relu_s > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (relu_s < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = relu_s[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/df_mac_sequencer.sv
// Single-neuron dot-product sequencer: issues weight/pixel addresses,
// accumulates products and emits a scaled, saturated result with a done pulse.
module df_mac_sequencer
    import df_pkg::*;
#(
    parameter int                       N_INPUTS  = 10,
    parameter int                       ADDR_W    = 4,
    parameter int                       DATA_W    = DF_DATA_W,
    parameter int                       ACC_W     = DF_ACC_W,
    parameter int                       FRAC_BITS = DF_FRAC_BITS,
    parameter logic signed [DATA_W-1:0] BIAS      = {DATA_W{1'b0}},
    parameter bit                       RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     mem_start,
    output logic [ADDR_W-1:0]        pixel_addr,
    input  logic signed [DATA_W-1:0] w,
    input  logic                     w_ready,
    input  logic signed [DATA_W-1:0] pixel,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result
);
    localparam int                TMO_W     = $clog2(DF_DRAIN_TIMEOUT);
    localparam int                CNT_W     = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_INPUTS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_INPUTS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DF_DRAIN_TIMEOUT - 1);

    df_state_e                state_r, state_nxt_s;
    logic                     mem_start_r, mem_start_nxt_s;
    logic [ADDR_W-1:0]        addr_r, addr_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     done_r, done_nxt_s;
    logic signed [DATA_W-1:0] result_r, result_nxt_s;
    logic signed [ACC_W-1:0]  acc_r, acc_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic [TMO_W-1:0]         tmo_r, tmo_nxt_s;

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic                       take_s;
    logic signed [DATA_W-1:0]   scaled_s;

    assign prod_s     = w * pixel;
    assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    // Data is only counted while an evaluation is in flight and not yet full.
    assign take_s     = w_ready && (cnt_r < CNT_FULL)
                     && ((state_r == ISSUE) || (state_r == DRAIN));

    df_result_scaler #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .FRAC_BITS(FRAC_BITS),
        .BIAS     (BIAS),
        .RELU_EN  (RELU_EN)
    ) u_scaler (
        .acc   (acc_r),
        .result(scaled_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        mem_start_nxt_s = mem_start_r;
        addr_nxt_s      = addr_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        result_nxt_s    = result_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        tmo_nxt_s       = tmo_r;
        if (take_s) begin
            acc_nxt_s = acc_r + prod_ext_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
        end
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s     = ISSUE;
                    mem_start_nxt_s = 1'b1;
                    addr_nxt_s      = {ADDR_W{1'b0}};
                    busy_nxt_s      = 1'b1;
                    acc_nxt_s       = {ACC_W{1'b0}};
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    tmo_nxt_s       = {TMO_W{1'b0}};
                end else begin
                    mem_start_nxt_s = 1'b0;
                    addr_nxt_s      = {ADDR_W{1'b0}};
                    busy_nxt_s      = 1'b0;
                end
            end
            ISSUE: begin
                if (addr_r == ADDR_LAST) begin
                    state_nxt_s     = DRAIN;
                    mem_start_nxt_s = 1'b0;
                    addr_nxt_s      = {ADDR_W{1'b0}};
                    tmo_nxt_s       = {TMO_W{1'b0}};
                end else begin
                    addr_nxt_s = addr_r + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Leave on the final product, or give up after a run of idle data cycles.
                if ((cnt_r == CNT_FULL) || (take_s && (cnt_r == CNT_LAST))) begin
                    state_nxt_s = FINISH;
                end else if (!w_ready && (tmo_r == TMO_LAST)) begin
                    state_nxt_s = FINISH;
                end else if (!w_ready) begin
                    tmo_nxt_s = tmo_r + TMO_W'(1);
                end else begin
                    tmo_nxt_s = {TMO_W{1'b0}};
                end
            end
            FINISH: begin
                state_nxt_s  = IDLE;
                result_nxt_s = scaled_s;
                done_nxt_s   = 1'b1;
                busy_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s     = IDLE;
                mem_start_nxt_s = 1'b0;
                addr_nxt_s      = {ADDR_W{1'b0}};
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_start_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            tmo_r       <= {TMO_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            mem_start_r <= mem_start_nxt_s;
            addr_r      <= addr_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            result_r    <= result_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            tmo_r       <= tmo_nxt_s;
        end
    end

    assign mem_start  = mem_start_r;
    assign pixel_addr = addr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
endmodule
